// File: rtl/weight_column_encoder_if.sv
// Handshake and column-control bundle between the weight column encoder and the vertical MAC.
// The master modport is the encoder view; the slave modport is the producer/MAC environment view.
interface weight_column_encoder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16,
  parameter int SEL_WIDTH  = 3
);
  logic                                     in_valid;
  logic                                     in_ready;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]    weight;
  logic                                     out_valid;
  logic                                     out_ready;
  logic [VEC_LENGTH/2-1:0][SEL_WIDTH-1:0]   act_sel;
  logic [VEC_LENGTH/2-1:0]                  act_val;
  logic [VEC_LENGTH/8-1:0]                  is_skip_zero;
  logic [2:0]                               column_idx;
  logic                                     is_msb;
  logic                                     out_last;

  modport master (
    input  in_valid, weight, out_ready,
    output in_ready, out_valid, act_sel, act_val, is_skip_zero, column_idx, is_msb, out_last
  );

  modport slave (
    output in_valid, weight, out_ready,
    input  in_ready, out_valid, act_sel, act_val, is_skip_zero, column_idx, is_msb, out_last
  );
endinterface

// File: rtl/weight_column_encoder.sv
// Walks the bit columns of a signed weight vector MSB to LSB and emits sparse activation-select controls.
// Optional macro ZERO_COLUMN_SKIP_EN suppresses all-zero columns other than column 0.
module weight_column_encoder #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16,
  parameter int SEL_WIDTH  = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  weight_column_encoder_if.master   bus
);

  localparam int GROUPS = VEC_LENGTH / 8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                                state;
  logic [2:0]                            col;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] weightReg;
  logic [2:0]                            firstCol;
  logic [2:0]                            nextCol;

`ifdef ZERO_COLUMN_SKIP_EN
  logic [DATA_WIDTH-1:0] storedNonZero;
  logic [DATA_WIDTH-1:0] incomingNonZero;

  // Highest non-zero column strictly below limit, falling back to column 0.
  function automatic logic [2:0] highestBelow(input logic [DATA_WIDTH-1:0] mask, input logic [3:0] limit);
    logic [2:0] r;
    r = '0;
    for (int c = 1; c < DATA_WIDTH; c++) begin
      if (mask[c] && (c < int'(limit))) r = 3'(c);
    end
    return r;
  endfunction

  always_comb begin
    storedNonZero   = '0;
    incomingNonZero = '0;
    for (int c = 0; c < DATA_WIDTH; c++) begin
      for (int i = 0; i < VEC_LENGTH; i++) begin
        storedNonZero[c]   = storedNonZero[c]   | weightReg[i][c];
        incomingNonZero[c] = incomingNonZero[c] | bus.weight[i][c];
      end
    end
  end

  assign firstCol = highestBelow(incomingNonZero, 4'(DATA_WIDTH));
  assign nextCol  = highestBelow(storedNonZero, {1'b0, col});
`else
  assign firstCol = 3'(DATA_WIDTH - 1);
  assign nextCol  = col - 3'd1;
`endif

  // in_ready/out_valid are registered alongside the state so they never glitch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      col           <= 3'(DATA_WIDTH - 1);
      weightReg     <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            weightReg     <= bus.weight;
            col           <= firstCol;
            state         <= RUN;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b1;
          end
        end
        RUN: begin
          if (bus.out_ready) begin
            if (col == 3'd0) begin
              state         <= IDLE;
              bus.in_ready  <= 1'b1;
              bus.out_valid <= 1'b0;
            end else begin
              col <= nextCol;
            end
          end
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end

  logic [7:0] colBits;
  logic [7:0] chosen;
  logic       takeOnes;
  int         nextFree;
  int         m;

  // Each selector m reaches positions m..m+4, so a selected position p is given to the
  // lowest free selector that still reaches it; at most four positions are ever selected.
  always_comb begin
    bus.act_sel      = '0;
    bus.act_val      = '0;
    bus.is_skip_zero = '0;
    bus.out_last     = 1'b0;
    bus.column_idx   = col;
    bus.is_msb       = (col == 3'(DATA_WIDTH - 1));
    colBits          = '0;
    chosen           = '0;
    takeOnes         = 1'b0;
    nextFree         = 0;
    m                = 0;
    if (state == RUN) begin
      bus.out_last = (col == 3'd0);
      for (int g = 0; g < GROUPS; g++) begin
        for (int k = 0; k < 8; k++) colBits[k] = weightReg[8*g+k][col];
        takeOnes             = ($countones(colBits) <= 4);
        bus.is_skip_zero[g]  = takeOnes;
        chosen               = takeOnes ? colBits : ~colBits;
        nextFree             = 0;
        for (int k = 0; k < 8; k++) begin
          if (chosen[k]) begin
            m = ((k - 4) > nextFree) ? (k - 4) : nextFree;
            if (m < 4) begin
              bus.act_val[3'(4*g + m)] = 1'b1;
              bus.act_sel[3'(4*g + m)] = SEL_WIDTH'(k - m);
            end
            nextFree = m + 1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_weight_column_encoder.sv
// Randomized self-checking bench for weight_column_encoder against a queue-based reference model.
module tb_weight_column_encoder;

  localparam int DW   = 8;
  localparam int VL   = 16;
  localparam int SW   = 3;
  localparam int NSEL = VL / 2;
`ifdef ZERO_COLUMN_SKIP_EN
  localparam int ZERO_BEATS = 1;
`else
  localparam int ZERO_BEATS = 8;
`endif

  typedef logic [VL-1:0][DW-1:0] wvec_t;
  typedef struct packed {
    logic [NSEL-1:0][SW-1:0] sel;
    logic [NSEL-1:0]         val;
    logic [1:0]              skip;
    logic [2:0]              idx;
    logic                    msb;
    logic                    last;
  } beat_t;

  logic clk;
  logic reset;

  weight_column_encoder_if #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .SEL_WIDTH(SW)) bus ();

  weight_column_encoder #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .SEL_WIDTH(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t obsQ[$];
  beat_t expQ[$];
  int    cycles;
  int    stalls;
  bit    timedOut;
  int    passCount  = 0;
  int    totalCount = 0;

  function automatic beat_t sampleBeat();
    beat_t b;
    b.sel  = bus.act_sel;
    b.val  = bus.act_val;
    b.skip = bus.is_skip_zero;
    b.idx  = bus.column_idx;
    b.msb  = bus.is_msb;
    b.last = bus.out_last;
    return b;
  endfunction

  function automatic wvec_t randomVec(input bit sparse);
    wvec_t      w;
    logic [7:0] colMask;
    colMask = 8'($urandom) & 8'($urandom);
    for (int i = 0; i < VL; i++) w[i] = sparse ? (8'($urandom) & colMask) : 8'($urandom);
    return w;
  endfunction

  // Reference: list the selected positions of each group column and hand them out greedily.
  function automatic void buildModel(input wvec_t w);
    expQ.delete();
    for (int c = DW - 1; c >= 0; c--) begin
      beat_t b;
      int    ones;
      int    m;
      int    pos[$];
      bit    anySet;
      b      = '0;
      anySet = 1'b0;
      for (int i = 0; i < VL; i++) anySet = anySet | w[i][c];
`ifdef ZERO_COLUMN_SKIP_EN
      if (c != 0 && !anySet) continue;
`endif
      b.idx  = 3'(c);
      b.msb  = (c == DW - 1);
      b.last = (c == 0);
      for (int g = 0; g < 2; g++) begin
        ones = 0;
        for (int k = 0; k < 8; k++) ones += int'(w[8*g+k][c]);
        b.skip[g] = (ones <= 4);
        pos.delete();
        for (int k = 0; k < 8; k++) if (w[8*g+k][c] == b.skip[g]) pos.push_back(k);
        m = -1;
        foreach (pos[j]) begin
          m = ((m + 1) > (pos[j] - 4)) ? (m + 1) : (pos[j] - 4);
          b.val[3'(4*g + m)] = 1'b1;
          b.sel[3'(4*g + m)] = 3'(pos[j] - m);
        end
      end
      if (anySet || !anySet) expQ.push_back(b);
    end
  endfunction

  task automatic waitIdle();
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) timedOut = 1'b1;
  endtask

  task automatic applyStimulus(input wvec_t w, input int readyPct);
    int n;
    obsQ.delete();
    timedOut = 1'b0;
    stalls   = 0;
    cycles   = 0;
    @(negedge clk);
    waitIdle();
    if (timedOut) return;
    bus.in_valid = 1'b1;
    bus.weight   = w;
    @(negedge clk);
    cycles       = 1;
    bus.in_valid = 1'b0;
    bus.weight   = randomVec(1'b0);
    n = 0;
    while (n < 300) begin
      if (bus.in_ready && !bus.out_valid) break;
      bus.out_ready = (int'($urandom_range(99)) < readyPct);
      if (bus.out_valid && bus.out_ready) obsQ.push_back(sampleBeat());
      if (bus.out_valid && !bus.out_ready) stalls++;
      @(negedge clk);
      cycles++;
      n++;
    end
    bus.out_ready = 1'b0;
    if (n >= 300) timedOut = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    totalCount++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("[TB] FAIL reset_handshake: got valid=%b ready=%b expected valid=0 ready=1", bus.out_valid, bus.in_ready);
    else passCount++;
    totalCount++;
    if (sampleBeat() !== beat_t'({24'h0, 8'h0, 2'b00, 3'd7, 1'b1, 1'b0})) $display("[TB] FAIL reset_controls: got %h expected %h", sampleBeat(), beat_t'({24'h0, 8'h0, 2'b00, 3'd7, 1'b1, 1'b0}));
    else passCount++;
    reset = 1'b1;
  endtask

  task automatic test_zero_vector();
    beat_t b;
    applyStimulus('0, 100);
    totalCount++;
    if (timedOut || obsQ.size() != ZERO_BEATS) $display("[TB] FAIL zero_beats: got %0d (timeout=%0b) expected %0d", obsQ.size(), timedOut, ZERO_BEATS);
    else passCount++;
    totalCount++;
    if (cycles != ZERO_BEATS + 1) $display("[TB] FAIL zero_cycles: got %0d expected %0d", cycles, ZERO_BEATS + 1);
    else passCount++;
    foreach (obsQ[i]) begin
      b      = '0;
      b.skip = 2'b11;
      b.idx  = 3'(ZERO_BEATS - 1 - i);
      b.msb  = (b.idx == 3'd7);
      b.last = (i == ZERO_BEATS - 1);
      totalCount++;
      if (obsQ[i] !== b) $display("[TB] FAIL zero_beat%0d: got %h expected %h", i, obsQ[i], b);
      else passCount++;
    end
  endtask

  task automatic test_all_ones();
    beat_t b;
    applyStimulus({VL{8'hFF}}, 100);
    totalCount++;
    if (timedOut || obsQ.size() != 8) $display("[TB] FAIL ones_beats: got %0d expected 8", obsQ.size());
    else passCount++;
    foreach (obsQ[i]) begin
      b      = '0;
      b.idx  = 3'(7 - i);
      b.msb  = (i == 0);
      b.last = (i == 7);
      totalCount++;
      if (obsQ[i] !== b) $display("[TB] FAIL ones_beat%0d: got %h expected %h", i, obsQ[i], b);
      else passCount++;
    end
  endtask

  task automatic test_sparse_patterns();
    wvec_t w;
    w = '0; w[7] = 8'h80;
    applyStimulus(w, 100);
    totalCount++;
    if (obsQ[0].val !== 8'b0000_1000 || obsQ[0].sel !== 24'(4 << 9) || obsQ[0].skip !== 2'b11) $display("[TB] FAIL msb_only: got val=%b sel=%h skip=%b expected val=00001000 sel=000800 skip=11", obsQ[0].val, obsQ[0].sel, obsQ[0].skip);
    else passCount++;
    w = '0; w[0] = 8'h80; w[1] = 8'h80; w[2] = 8'h80; w[7] = 8'h80;
    applyStimulus(w, 100);
    totalCount++;
    if (obsQ[0].val !== 8'b0000_1111 || obsQ[0].sel !== 24'(4 << 9)) $display("[TB] FAIL four_ones: got val=%b sel=%h expected val=00001111 sel=000800", obsQ[0].val, obsQ[0].sel);
    else passCount++;
    w = '0;
    foreach (w[i]) if (i < 8 && ((8'b1101_0111 >> i) & 8'd1) != 0) w[i] = 8'h80;
    applyStimulus(w, 100);
    totalCount++;
    if (obsQ[0].val !== 8'b0000_0011 || obsQ[0].sel !== 24'h000023 || obsQ[0].skip !== 2'b10) $display("[TB] FAIL zero_select: got val=%b sel=%h skip=%b expected val=00000011 sel=000023 skip=10", obsQ[0].val, obsQ[0].sel, obsQ[0].skip);
    else passCount++;
  endtask

  task automatic test_random();
    wvec_t w;
    for (int t = 0; t < 25; t++) begin
      w = randomVec(t[0]);
      buildModel(w);
      applyStimulus(w, int'($urandom_range(30, 100)));
      totalCount++;
      if (timedOut || obsQ.size() != expQ.size() || cycles != expQ.size() + stalls + 1) $display("[TB] FAIL rand%0d_length: got beats=%0d cycles=%0d expected beats=%0d cycles=%0d", t, obsQ.size(), cycles, expQ.size(), expQ.size() + stalls + 1);
      else passCount++;
      foreach (expQ[i]) begin
        totalCount++;
        if (obsQ[i] !== expQ[i]) $display("[TB] FAIL rand%0d_beat%0d: got %h expected %h", t, i, obsQ[i], expQ[i]);
        else passCount++;
      end
    end
  endtask

  task automatic test_backpressure();
    wvec_t w;
    beat_t snap;
    int    n;
    w = randomVec(1'b0); w[0] = 8'hFF;
    buildModel(w);
    timedOut = 1'b0;
    @(negedge clk);
    waitIdle();
    bus.in_valid = 1'b1; bus.weight = w; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.column_idx != 3'd4 && n < 20) begin @(negedge clk); n++; end
    bus.out_ready = 1'b0;
    snap = sampleBeat();
    totalCount++;
    if (snap !== expQ[3] || !bus.out_valid) $display("[TB] FAIL bp_column4: got %h valid=%b expected %h valid=1", snap, bus.out_valid, expQ[3]);
    else passCount++;
    repeat (5) begin
      @(negedge clk);
      totalCount++;
      if (sampleBeat() !== snap || bus.out_valid !== 1'b1) $display("[TB] FAIL bp_hold: got %h valid=%b expected %h valid=1", sampleBeat(), bus.out_valid, snap);
      else passCount++;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    waitIdle();
    bus.out_ready = 1'b0;
    totalCount++;
    if (timedOut) $display("[TB] FAIL bp_drain: got timeout expected return to idle");
    else passCount++;
  endtask

  task automatic test_reset_mid_vector();
    wvec_t w;
    int    n;
    w = randomVec(1'b0); w[0] = 8'hFF;
    @(negedge clk);
    waitIdle();
    bus.in_valid = 1'b1; bus.weight = w; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.column_idx != 3'd2 && n < 20) begin @(negedge clk); n++; end
    bus.out_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    totalCount++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || sampleBeat() !== beat_t'({24'h0, 8'h0, 2'b00, 3'd7, 1'b1, 1'b0})) $display("[TB] FAIL mid_reset: got valid=%b ready=%b ctl=%h expected valid=0 ready=1 ctl=%h", bus.out_valid, bus.in_ready, sampleBeat(), beat_t'({24'h0, 8'h0, 2'b00, 3'd7, 1'b1, 1'b0}));
    else passCount++;
    @(negedge clk);
    reset = 1'b1;
    w = randomVec(1'b1); w[0] = 8'hFF;
    buildModel(w);
    applyStimulus(w, 100);
    totalCount++;
    if (timedOut || obsQ.size() != expQ.size() || obsQ[0].idx !== 3'd7) $display("[TB] FAIL post_reset_start: got beats=%0d idx=%0d expected beats=%0d idx=7", obsQ.size(), obsQ[0].idx, expQ.size());
    else passCount++;
    foreach (expQ[i]) begin
      totalCount++;
      if (obsQ[i] !== expQ[i]) $display("[TB] FAIL post_reset_beat%0d: got %h expected %h", i, obsQ[i], expQ[i]);
      else passCount++;
    end
  endtask

  task automatic test_back_to_back();
    wvec_t wa;
    wvec_t wb;
    bit    bubble;
    int    n;
    wa = randomVec(1'b1);
    wb = randomVec(1'b0);
    timedOut = 1'b0;
    @(negedge clk);
    waitIdle();
    bus.in_valid = 1'b1; bus.weight = wa; bus.out_ready = 1'b1;
    for (int v = 0; v < 2; v++) begin
      buildModel(v == 0 ? wa : wb);
      obsQ.delete();
      @(negedge clk);
      bus.weight = wb;
      if (v == 1) bus.in_valid = 1'b0;
      n = 0;
      while (!bus.in_ready && n < 50) begin
        if (bus.out_valid) obsQ.push_back(sampleBeat());
        @(negedge clk);
        n++;
      end
      bubble = bus.in_ready && !bus.out_valid;
      totalCount++;
      if (!bubble || obsQ.size() != expQ.size()) $display("[TB] FAIL b2b%0d_length: got beats=%0d bubble=%0b expected beats=%0d bubble=1", v, obsQ.size(), bubble, expQ.size());
      else passCount++;
      foreach (expQ[i]) begin
        totalCount++;
        if (obsQ[i] !== expQ[i]) $display("[TB] FAIL b2b%0d_beat%0d: got %h expected %h", v, i, obsQ[i], expQ[i]);
        else passCount++;
      end
    end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.weight    = '0;
    test_reset();
    test_zero_vector();
    test_all_ones();
    test_sparse_patterns();
    test_random();
    test_backpressure();
    test_reset_mid_vector();
    test_back_to_back();
    $display("[TB] %0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/weight_column_encoder.md
Name: weight_column_encoder

Overview:
- Producer side of the bit-column MAC control interface.
- Accepts a vector of VEC_LENGTH signed weights and walks their bit columns from MSB to LSB.
- For each column it emits the sparse activation-select controls consumed by the vertical MAC unit: act_sel, act_val, is_skip_zero, column_idx and is_msb.
- One column is emitted per accepted output beat, under a valid/ready handshake on both sides.

Parameters:
DATA_WIDTH, 8, weight width and number of bit columns per vector
VEC_LENGTH, 16, weights per vector; fixed as 2 groups of 8
SEL_WIDTH, 3, width of each act_sel entry (values 0..4)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
in_valid  input  1  weight vector present
in_ready  output  1  encoder can accept a vector
weight  input  DATA_WIDTH x VEC_LENGTH  signed weights, two's complement
out_valid  output  1  column controls valid
out_ready  input  1  MAC consumes column this cycle
act_sel  output  SEL_WIDTH x VEC_LENGTH/2  mux offset per selector
act_val  output  1 x VEC_LENGTH/2  selector enable
is_skip_zero  output  1 x VEC_LENGTH/8  1 = selected set is the ones, 0 = selected set is the zeros
column_idx  output  3  bit position of the current column
is_msb  output  1  current column is the sign column
out_last  output  1  final column of the vector

Behaviour:
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=1.
- IDLE transitions: on in_valid&&in_ready, register all weights, set col=DATA_WIDTH-1, go to RUN.
- Latency: first column is valid the cycle after acceptance.
- RUN: outputs are decoded combinationally from the registered weights and col. They hold stable while out_valid&&!out_ready.
- Advance rule: on out_valid&&out_ready, if col==0 go to IDLE; else col decrements by 1.
- Throughput: DATA_WIDTH+1 cycles per vector. The IDLE bubble is mandatory.
- Static outputs: column_idx=col; is_msb=(col==DATA_WIDTH-1); out_last=(col==0).
- Per group g (weights 8g..8g+7), column bit vector b[k]=weight[8g+k][col]; n1=popcount(b).
  - If n1<=4: is_skip_zero[g]=1 and the selected positions are the ones.
  - Else: is_skip_zero[g]=0 and the selected positions are the zeros (at most 3).
  - Tie n1==4 selects the ones.
- Selector assignment within group g: selector m (0..3) covers positions m..m+4.
  - Take the selected positions ascending, p_0<p_1<...
  - Greedy: m_k = max(m_{k-1}+1, p_k-4), with m_{-1}=-1.
  - Set act_val[4g+m_k]=1 and act_sel[4g+m_k]=p_k-m_k.
  - Unassigned selectors: act_val=0, act_sel=0.
  - The greedy never exceeds m=3.
- Reset (reset low, asynchronous, any state including mid-vector):
  - FSM goes to IDLE and col=DATA_WIDTH-1.
  - Stored weights clear to 0.
  - out_valid=0, in_ready=1.
  - All control outputs read 0, except column_idx=DATA_WIDTH-1 and is_msb=1.
  - A partially emitted vector is discarded.
- in_valid while in RUN is ignored (in_ready=0). The weight input is sampled only on acceptance.

Optional Feature:
- Macro ZERO_COLUMN_SKIP_EN.
- When defined:
  - In RUN, columns whose 16 bits are all 0 are not emitted, except column 0, which is always emitted so that out_last is seen.
  - col jumps to the next lower non-zero column (or 0) in the same cycle as the advance.
  - On acceptance, the initial col is the highest non-zero column (or 0).
  - A vector with k non-zero columns among 7..1 takes k+2 cycles.
- When undefined: all DATA_WIDTH columns are always emitted.

Test Plan:
- Vector of all zeros, out_ready=1 (macro off):
  - 8 beats, column_idx 7..0.
  - is_msb only on the first beat, out_last only on the last.
  - act_val all 0, is_skip_zero=2'b11.
  - in_ready returns 1 after 9 cycles.
- All weights 8'hFF:
  - Every column gives n1=8, so is_skip_zero=2'b00 and act_val all 0.
- Group 0 column-7 bits 8'b1000_0000 (w7=-128, others 0):
  - beat 1: act_val[3]=1, act_sel[3]=4, others 0, is_skip_zero[0]=1.
- Group 0 column bits at positions {0,1,2,7}:
  - act_val[3:0]=4'b1111, act_sel={4,0,0,0} for selectors 3..0.
- Group 0 bits 8'b1101_0111 (zeros at positions 3,5):
  - is_skip_zero[0]=0.
  - act_val[0]=1 with sel 3; act_val[1]=1 with sel 4; act_val[3:2]=0.
- Backpressure and reset:
  - Holding out_ready=0 for 5 cycles on column 4 keeps all outputs stable.
  - Asserting reset low during column 2 forces out_valid=0 and in_ready=1 immediately.
  - A new vector accepted afterward starts at column 7.
  - With ZERO_COLUMN_SKIP_EN and weights all 8'h01: exactly one beat, column_idx=0, out_last=1.
